// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring divide iteration, using the shared ALU result.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         is_div,
    input  logic [N-1:0] hi,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] m,
    input  logic [N-1:0] alu_result,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_control,
    output logic [N-1:0] hi_next,
    output logic [N-1:0] lo_next
);

    logic [N-1:0] shifted;
    logic         carry;
    logic         take;

    always_comb begin
        alu_a       = hi;
        alu_b       = lo[0] ? m : '0;
        alu_control = ALU_ADD;
        hi_next     = hi;
        lo_next     = lo;
        shifted     = {hi[N-2:0], lo[N-1]};
        carry       = 1'b0;
        take        = 1'b0;
        if (is_div) begin
            // hi holds the partial remainder, lo the dividend/quotient shift register
            alu_a       = shifted;
            alu_b       = m;
            alu_control = ALU_SUB;
            take        = hi[N-1] | (shifted >= m);
            hi_next     = take ? alu_result : shifted;
            lo_next     = {lo[N-2:0], take};
        end else begin
            carry   = (alu_result < hi);
            hi_next = {carry, alu_result[N-1:1]};
            lo_next = {alu_result[0], lo[N-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU controller driving the core's shared add/sub ALU.
// Optional MULDIV_EARLY_EXIT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module alu_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] result,
    output logic         div_by_zero,
    output logic         busy,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_control,
    input  logic [N-1:0] alu_result
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_e       state, state_nx;
    op_e          op_q, op_d;
    logic [N-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [N-1:0] result_q, result_d;
    logic         dbz_q, dbz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         last_c;

    logic [N-1:0] step_a, step_b, hi_nx, lo_nx;
    logic [1:0]   step_ctl;

`ifdef MULDIV_EARLY_EXIT_EN
    logic [N-1:0] mrem_q, mrem_d;
`endif

    muldiv_step #(.N(N)) u_step (
        .is_div      (op_q[1]),
        .hi          (hi_q),
        .lo          (lo_q),
        .m           (m_q),
        .alu_result  (alu_result),
        .alu_a       (step_a),
        .alu_b       (step_b),
        .alu_control (step_ctl),
        .hi_next     (hi_nx),
        .lo_next     (lo_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        last_c   = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
        mrem_d   = mrem_q;
`endif
        case (state)
            IDLE: begin
                if (start_valid) begin
                    op_d  = op_e'(op);
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    hi_d  = '0;
                    if (op[1]) begin
                        lo_d = operand_a;
                        m_d  = operand_b;
                        if (operand_b == '0) begin
                            state_nx = DONE;
                            dbz_d    = 1'b1;
                            result_d = op[0] ? operand_a : '1;
                        end else begin
                            state_nx = BUSY;
                        end
                    end else begin
                        lo_d     = operand_b;
                        m_d      = operand_a;
                        state_nx = BUSY;
`ifdef MULDIV_EARLY_EXIT_EN
                        if (operand_b == '0) begin
                            state_nx = DONE;
                            result_d = '0;
                        end
`endif
                    end
`ifdef MULDIV_EARLY_EXIT_EN
                    mrem_d = operand_b;
`endif
                end
            end
            BUSY: begin
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q + CW'(1);
                last_c = (cnt_q == CW'(N - 1));
`ifdef MULDIV_EARLY_EXIT_EN
                mrem_d = mrem_q >> 1;
                // No multiplier bits left: realign the partial product by the skipped count
                if (!op_q[1] && (mrem_q[N-1:1] == '0)) begin
                    {hi_d, lo_d} = {hi_nx, lo_nx} >> (CW'(N - 1) - cnt_q);
                    last_c       = 1'b1;
                end
`endif
                if (last_c) begin
                    state_nx = DONE;
                    // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half
                    result_d = op_q[0] ? hi_d : lo_d;
                end
            end
            DONE: begin
                if (result_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            mrem_q   <= '0;
`endif
        end else begin
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_EARLY_EXIT_EN
            mrem_q   <= mrem_d;
`endif
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state == BUSY);
    assign result_valid = (state == DONE);
    assign result       = result_q;
    assign div_by_zero  = dbz_q;
    assign alu_a        = busy ? step_a   : '0;
    assign alu_b        = busy ? step_b   : '0;
    assign alu_control  = busy ? step_ctl : ALU_ADD;

endmodule
